// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture write-side sequencer.
//  - cam_state_e : capture FSM state encoding
//  - QVGA/VGA default frame geometry
//  - PACK_W / pack_bytes : width and layout of a packed byte pair
package cam_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StVblank,
        StCapture,
        StDone
    } cam_state_e;

    localparam int unsigned QVGA_H_PIX   = 320;
    localparam int unsigned QVGA_V_LINES = 240;
    localparam int unsigned VGA_H_PIX    = 640;
    localparam int unsigned VGA_V_LINES  = 480;

    // A pixel is built from two camera bytes, first byte in the MSBs.
    localparam int unsigned PACK_W = 16;

    function automatic logic [PACK_W-1:0] pack_bytes(input logic [7:0] byte0,
                                                     input logic [7:0] byte1);
        return {byte0, byte1};
    endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Byte-pair packer for the camera capture path.
// Ports:
//  Pclk, rst     : pixel clock, synchronous active-high reset
//  en_i          : a registered camera byte is valid this cycle
//  line_start_i  : first byte of a line; forces it to be treated as byte0
//  data_i        : registered camera byte
//  phase_o       : 1 when a byte0 is held waiting for its partner
//  pix_valid_o   : this cycle's byte completes a pixel
//  pix_word_o    : packed pixel, MSBs of {byte0, byte1}
module cam_byte_packer
    import cam_pkg::*;
#(
    parameter int unsigned PIX_W = 16
) (
    input  logic             Pclk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             line_start_i,
    input  logic [7:0]       data_i,
    output logic             phase_o,
    output logic             pix_valid_o,
    output logic [PIX_W-1:0] pix_word_o
);

    logic              phase_q, phase_d;
    logic [7:0]        byte0_q, byte0_d;
    logic              cur_phase;
    logic [PACK_W-1:0] packed_word;

    always_comb begin
        // A line start resynchronises the pairing even if the previous line was odd.
        cur_phase = line_start_i ? 1'b0 : phase_q;
        phase_d   = cur_phase;
        byte0_d   = byte0_q;
        if (en_i) begin
            phase_d = ~cur_phase;
            if (!cur_phase) begin
                byte0_d = data_i;
            end
        end
    end

    always_ff @(posedge Pclk) begin
        if (rst) begin
            phase_q <= 1'b0;
            byte0_q <= 8'h00;
        end else begin
            phase_q <= phase_d;
            byte0_q <= byte0_d;
        end
    end

    assign packed_word = pack_bytes(byte0_q, data_i);
    assign pix_valid_o = en_i & cur_phase;
    assign pix_word_o  = packed_word[PACK_W-1 -: PIX_W];
    assign phase_o     = phase_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera pixel FIFO write-side sequencer. Arms on start, aligns to a full VSYNC blanking
// interval, packs HREF-qualified byte pairs into pixels and writes them to the FIFO, while
// checking frame geometry and flagging pixels dropped on a full FIFO.
// Ports:
//  Pclk, rst   : pixel clock, synchronous active-high reset
//  start       : one-cycle capture request, honoured only when idle
//  vsync/href  : camera sync inputs (already synchronous to Pclk)
//  cam_data    : camera byte
//  fifo_full   : FIFO full flag
//  fifo_wr     : single-cycle FIFO write strobe
//  fifo_din    : FIFO write data
//  busy        : not idle
//  frame_done  : one-cycle pulse at end of frame
//  overflow    : sticky, a pixel was dropped on full
//  size_err    : sticky, line length or line count mismatch
//  line_count  : completed lines in current/last frame
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned PIX_W   = 16,
    parameter int unsigned H_PIX   = VGA_H_PIX,
    parameter int unsigned V_LINES = VGA_V_LINES,
    parameter int unsigned CNT_W   = 10
) (
    input  logic             Pclk,
    input  logic             rst,
    input  logic             start,
    input  logic             vsync,
    input  logic             href,
    input  logic [7:0]       cam_data,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic [PIX_W-1:0] fifo_din,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow,
    output logic             size_err,
    output logic [CNT_W-1:0] line_count
);

    cam_state_e state_q, state_d;

    logic             vsync_q, vsync_prev_q;
    logic             href_q, href_prev_q;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_count_q, line_count_d;
    logic             overflow_q, overflow_d;
    logic             size_err_q, size_err_d;
    logic             fifo_wr_q, fifo_wr_d;
    logic [PIX_W-1:0] fifo_din_q, fifo_din_d;

    logic             vsync_rise, vsync_fall, href_rise, href_fall;
    logic             in_capture, start_ok, line_start, line_end;
    logic             pack_phase, pix_valid;
    logic [PIX_W-1:0] pix_word;

    // Edges are taken on the registered copies, never on the raw pins.
    assign vsync_rise = vsync_q & ~vsync_prev_q;
    assign vsync_fall = ~vsync_q & vsync_prev_q;
    assign href_rise  = href_q & ~href_prev_q;
    assign href_fall  = ~href_q & href_prev_q;

    assign in_capture = (state_q == StCapture);
    assign start_ok   = (state_q == StIdle) & start;
    assign line_start = in_capture & href_rise;
    assign line_end   = in_capture & href_fall;

    cam_byte_packer #(
        .PIX_W (PIX_W)
    ) u_packer (
        .Pclk         (Pclk),
        .rst          (rst),
        .en_i         (in_capture & href_q),
        .line_start_i (line_start),
        .data_i       (data_q),
        .phase_o      (pack_phase),
        .pix_valid_o  (pix_valid),
        .pix_word_o   (pix_word)
    );

    // FSM state register
    always_ff @(posedge Pclk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start)      state_d = StArm;
            StArm:     if (vsync_rise) state_d = StVblank;
            StVblank:  if (vsync_fall) state_d = StCapture;
            StCapture: if (vsync_rise) state_d = StDone;
            StDone:                    state_d = StIdle;
            default:                   state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
    end

    // Counters, sticky flags and FIFO write stage
    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        line_count_d = line_count_q;
        overflow_d   = overflow_q;
        size_err_d   = size_err_q;
        fifo_wr_d    = 1'b0;
        fifo_din_d   = fifo_din_q;

        if (start_ok) begin
            overflow_d   = 1'b0;
            size_err_d   = 1'b0;
            line_count_d = '0;
        end

        if (line_start) begin
            pix_cnt_d = '0;
        end else if (pix_valid && pix_cnt_q != '1) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end

        // Fullness is sampled once, when the pixel forms; a dropped pixel still counts.
        if (pix_valid) begin
            if (fifo_full) begin
                overflow_d = 1'b1;
            end else begin
                fifo_wr_d  = 1'b1;
                fifo_din_d = pix_word;
            end
        end

        if (line_end) begin
            if (line_count_q != '1) begin
                line_count_d = line_count_q + CNT_W'(1);
            end
            // A held byte0 at line end means an odd byte count.
            if (pix_cnt_q != CNT_W'(H_PIX) || pack_phase) begin
                size_err_d = 1'b1;
            end
        end

        if (state_q == StDone && line_count_q != CNT_W'(V_LINES)) begin
            size_err_d = 1'b1;
        end
    end

    always_ff @(posedge Pclk) begin
        if (rst) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_q       <= 1'b0;
            href_prev_q  <= 1'b0;
            data_q       <= 8'h00;
            pix_cnt_q    <= '0;
            line_count_q <= '0;
            overflow_q   <= 1'b0;
            size_err_q   <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_din_q   <= '0;
        end else begin
            vsync_q      <= vsync;
            vsync_prev_q <= vsync_q;
            href_q       <= href;
            href_prev_q  <= href_q;
            data_q       <= cam_data;
            pix_cnt_q    <= pix_cnt_d;
            line_count_q <= line_count_d;
            overflow_q   <= overflow_d;
            size_err_q   <= size_err_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_din_q   <= fifo_din_d;
        end
    end

    assign fifo_wr    = fifo_wr_q;
    assign fifo_din   = fifo_din_q;
    assign overflow   = overflow_q;
    assign size_err   = size_err_q;
    assign line_count = line_count_q;

endmodule
